// File: rtl/regfile.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : regfile
// Description : General-purpose integer register file at the write-back end
//               of the pipeline. One write port and two combinational read
//               ports with same-cycle write-to-read bypass. Register 0 is
//               hardwired to zero.
// Ports       : clk     - system clock, writes on rising edge
//               rst     - asynchronous active-high reset, clears storage
//               we      - write enable from write-back stage
//               waddr   - destination register index
//               wdata   - value to write
//               re1/re2 - read enables, ports 1/2
//               raddr1/raddr2 - read indices, ports 1/2
//               rdata1/rdata2 - read data, ports 1/2 (0 when disabled)
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module regfile #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 5,
   // Must equal 2**ADDR_WIDTH so every address decodes to a real register.
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [REG_WIDTH-1:0]  wdata,
   input  logic                  re1,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   output logic [REG_WIDTH-1:0]  rdata1,
   input  logic                  re2,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [REG_WIDTH-1:0]  rdata2
);

   // Flattened view of the architectural state; entry 0 is a constant.
   logic [REG_WIDTH-1:0] w_regs [NUM_REGS];

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == 0) begin : g_zero
         // No storage for r0: writes to it vanish and it always reads zero.
         assign w_regs[i] = '0;
      end else begin : g_flop
         logic [REG_WIDTH-1:0] r_q;

         // Reset has priority, so a write coinciding with rst is blocked and
         // the first possible write is the first edge seen with rst low.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_q <= '0;
            end else if (we && (waddr == ADDR_WIDTH'(i))) begin
               r_q <= wdata;
            end
         end

         assign w_regs[i] = r_q;
      end
   end

   // Read port 1: reset, disable and r0 all force zero before the bypass
   // check, so the bypass can never leak a write aimed at r0.
   always_comb begin
      rdata1 = '0;
      if (!rst && re1 && (raddr1 != '0)) begin
         if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
         end else begin
            rdata1 = w_regs[raddr1];
         end
      end
   end

   // Read port 2: identical priority chain, fully independent of port 1.
   always_comb begin
      rdata2 = '0;
      if (!rst && re2 && (raddr2 != '0)) begin
         if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
         end else begin
            rdata2 = w_regs[raddr2];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_regfile
// Description : Self-checking bench for regfile. Directed scenarios followed
//               by randomized traffic, compared against an array-based
//               architectural model of the register file.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_regfile;

   localparam int RW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [AW-1:0] waddr;
   logic [RW-1:0] wdata;
   logic          re1;
   logic [AW-1:0] raddr1;
   logic [RW-1:0] rdata1;
   logic          re2;
   logic [AW-1:0] raddr2;
   logic [RW-1:0] rdata2;

   always #5 clk = ~clk;

   regfile #(
      .REG_WIDTH (RW),
      .ADDR_WIDTH(AW),
      .NUM_REGS  (NR)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re1   (re1),
      .raddr1(raddr1),
      .rdata1(rdata1),
      .re2   (re2),
      .raddr2(raddr2),
      .rdata2(rdata2)
   );

   // Architectural model: plain array of register contents.
   logic [RW-1:0] mem [NR];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] model_rd(input logic ren, input logic [AW-1:0] a);
      if (rst)                   return '0;
      if (!ren)                  return '0;
      if (a == '0)               return '0;
      if (we && (waddr == a))    return wdata;
      return mem[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NR; i++) mem[i] = '0;
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [RW-1:0] wd,
                        input logic r1, input logic [AW-1:0] a1,
                        input logic r2, input logic [AW-1:0] a2);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
   endtask

   task automatic check_ports(input string tag);
      check({tag, ".p1"}, rdata1, model_rd(re1, raddr1));
      check({tag, ".p2"}, rdata2, model_rd(re2, raddr2));
   endtask

   // Cross one rising edge, apply the same edge to the model, then move off it.
   task automatic step();
      @(posedge clk);
      if (rst) model_clear();
      else if (we && (waddr != '0)) mem[waddr] = wdata;
      #1;
   endtask

   task automatic cyc(input string tag);
      @(negedge clk);
      check_ports(tag);
      step();
   endtask

   initial begin
      rst = 1'b1;
      model_clear();
      drive(1'b1, 5'd5, 32'hFFFF_0000, 1'b1, 5'd5, 1'b1, 5'd5);
      #2;
      check("reset_state.p1", rdata1, 32'h0);
      check("reset_state.p2", rdata2, 32'h0);
      step();
      rst = 1'b0;

      // Reset clear: write r5, then assert rst between edges.
      drive(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b0, 5'd0);
      cyc("wr_r5");
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
      #2;
      check("r5_stored", rdata1, 32'h1234_5678);
      #1; rst = 1'b1; model_clear();
      #1;
      check("async_rst", rdata1, 32'h0);
      #1; rst = 1'b0;
      #1;
      check("after_rst", rdata1, 32'h0);
      step();
      @(negedge clk);
      check("after_rst_edge", rdata1, 32'h0);
      step();

      // Basic write then read through storage.
      drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("wr_r7");
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd8);
      @(negedge clk);
      check("rd_r7", rdata1, 32'hDEAD_BEEF);
      check("rd_r8", rdata2, 32'h0);
      step();

      // Zero register ignores writes, bypass included.
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
      @(negedge clk);
      check("r0_same", rdata1, 32'h0);
      check("r0_same.p2", rdata2, 32'h0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      check("r0_next", rdata1, 32'h0);
      step();

      // Bypass on both ports.
      drive(1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("wr_r3");
      drive(1'b1, 5'd3, 32'h2222_2222, 1'b1, 5'd3, 1'b1, 5'd3);
      @(negedge clk);
      check("byp.p1", rdata1, 32'h2222_2222);
      check("byp.p2", rdata2, 32'h2222_2222);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
      @(negedge clk);
      check("byp_held.p1", rdata1, 32'h2222_2222);
      check("byp_held.p2", rdata2, 32'h2222_2222);
      step();

      // Read disable and write to a different address.
      drive(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd7, 1'b1, 5'd7);
      @(negedge clk);
      check("dis.p1", rdata1, 32'h0);
      check("mixed.p2", rdata2, 32'hDEAD_BEEF);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd7);
      @(negedge clk);
      check("rd_r9", rdata1, 32'hA5A5_A5A5);
      check("rd_r7_again", rdata2, 32'hDEAD_BEEF);
      step();

      // Back-to-back writes to the same address.
      drive(1'b1, 5'd10, 32'h0BAD_F00D, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
      drive(1'b1, 5'd10, 32'hCAFE_0001, 1'b1, 5'd10, 1'b0, 5'd0);
      @(negedge clk);
      check("b2b_byp", rdata1, 32'hCAFE_0001);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0);
      @(negedge clk);
      check("b2b_last", rdata1, 32'hCAFE_0001);
      step();

      // Reset asserted during a write blocks it.
      drive(1'b1, 5'd4, 32'h5555_5555, 1'b1, 5'd4, 1'b0, 5'd0);
      #1; rst = 1'b1; model_clear();
      @(negedge clk);
      check("rst_wr_during", rdata1, 32'h0);
      step();
      #1; rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd7);
      @(negedge clk);
      check("rst_wr_r4", rdata1, 32'h0);
      check("rst_wr_r7", rdata2, 32'h0);
      step();

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 500; n++) begin
         rst = (($urandom % 60) == 0);
         if (rst) model_clear();
         drive(($urandom % 4) != 0, AW'($urandom), $urandom,
               ($urandom % 5) != 0, AW'($urandom),
               ($urandom % 5) != 0, AW'($urandom));
         // Frequently read what is being written to exercise the bypass.
         if (($urandom % 4) == 0) raddr1 = waddr;
         if (($urandom % 4) == 0) raddr2 = waddr;
         cyc("rnd");
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
